// File: rtl/cardinal_fetch_stage.sv
// Cardinal instruction-fetch stage and IF/ID pipeline register.
// Drives a 1-cycle-latency instruction memory, skids the returned word across stalls and applies branch redirects.
module cardinal_fetch_stage #(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
   parameter logic [31:0]     NOP_INSTR = 32'hF000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_en,
   input  logic [31:0]     imem_dout,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic [31:0]     if_id_instr,
   output logic [PC_W-1:0] if_id_pc,
   output logic            if_id_valid
);

   localparam logic [PC_W-1:0] PC_INC     = {{(PC_W-3){1'b0}}, 3'b100};
   localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

   logic [PC_W-1:0] r_pc;
   logic            r_req_valid;
   logic [PC_W-1:0] r_req_pc;
   logic            r_skid_valid;
   logic [31:0]     r_skid_instr;
   logic [PC_W-1:0] r_skid_pc;
   logic [31:0]     r_if_id_instr;
   logic [PC_W-1:0] r_if_id_pc;
   logic            r_if_id_valid;

   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_pc_nxt;
   logic            w_req_valid_nxt;
   logic [PC_W-1:0] w_req_pc_nxt;
   logic            w_skid_valid_nxt;
   logic [31:0]     w_skid_instr_nxt;
   logic [PC_W-1:0] w_skid_pc_nxt;
   logic [31:0]     w_if_id_instr_nxt;
   logic [PC_W-1:0] w_if_id_pc_nxt;
   logic            w_if_id_valid_nxt;

   assign w_target    = branch_target & ALIGN_MASK;
   assign imem_addr   = branch_taken ? w_target : r_pc;
   assign imem_en     = rst_n & (branch_taken | ~stall);
   assign if_id_instr = r_if_id_instr;
   assign if_id_pc    = r_if_id_pc;
   assign if_id_valid = r_if_id_valid;

   // Next-state selection: branch redirect beats stall beats normal flow.
   always_comb begin
      w_pc_nxt          = r_pc;
      w_req_valid_nxt   = r_req_valid;
      w_req_pc_nxt      = r_req_pc;
      w_skid_valid_nxt  = r_skid_valid;
      w_skid_instr_nxt  = r_skid_instr;
      w_skid_pc_nxt     = r_skid_pc;
      w_if_id_instr_nxt = r_if_id_instr;
      w_if_id_pc_nxt    = r_if_id_pc;
      w_if_id_valid_nxt = r_if_id_valid;
      if (branch_taken) begin
         // The sequential word in flight or in the skid is squashed; the bubble pc is held.
         w_pc_nxt          = w_target + PC_INC;
         w_req_valid_nxt   = 1'b1;
         w_req_pc_nxt      = w_target;
         w_skid_valid_nxt  = 1'b0;
         w_if_id_instr_nxt = NOP_INSTR;
         w_if_id_valid_nxt = 1'b0;
      end else if (stall) begin
         w_req_valid_nxt = 1'b0;
         if (r_req_valid) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_instr_nxt = imem_dout;
            w_skid_pc_nxt    = r_req_pc;
         end else begin
            w_skid_valid_nxt = r_skid_valid;
         end
      end else begin
         w_pc_nxt        = r_pc + PC_INC;
         w_req_valid_nxt = 1'b1;
         w_req_pc_nxt    = r_pc;
         if (r_skid_valid) begin
            w_if_id_instr_nxt = r_skid_instr;
            w_if_id_pc_nxt    = r_skid_pc;
            w_if_id_valid_nxt = 1'b1;
            w_skid_valid_nxt  = 1'b0;
         end else if (r_req_valid) begin
            w_if_id_instr_nxt = imem_dout;
            w_if_id_pc_nxt    = r_req_pc;
            w_if_id_valid_nxt = 1'b1;
         end else begin
            w_if_id_instr_nxt = NOP_INSTR;
            w_if_id_valid_nxt = 1'b0;
         end
      end
   end

   // State registers; reset discards any in-flight read by clearing req_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_req_valid   <= 1'b0;
         r_req_pc      <= {PC_W{1'b0}};
         r_skid_valid  <= 1'b0;
         r_skid_instr  <= 32'h0000_0000;
         r_skid_pc     <= {PC_W{1'b0}};
         r_if_id_instr <= NOP_INSTR;
         r_if_id_pc    <= {PC_W{1'b0}};
         r_if_id_valid <= 1'b0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_req_valid   <= w_req_valid_nxt;
         r_req_pc      <= w_req_pc_nxt;
         r_skid_valid  <= w_skid_valid_nxt;
         r_skid_instr  <= w_skid_instr_nxt;
         r_skid_pc     <= w_skid_pc_nxt;
         r_if_id_instr <= w_if_id_instr_nxt;
         r_if_id_pc    <= w_if_id_pc_nxt;
         r_if_id_valid <= w_if_id_valid_nxt;
      end
   end

endmodule

// File: tb/tb_cardinal_fetch_stage.sv
// Directed testbench for cardinal_fetch_stage: memory model returns the read address as data.
// A second instance with RESET_PC near the top of the address space checks PC wrap.
module tb_cardinal_fetch_stage;

   localparam logic [31:0] NOP = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0000_0000;

   logic [31:0] imem_addr, imem_dout = 32'h0000_0000;
   logic        imem_en;
   logic [31:0] if_id_instr, if_id_pc;
   logic        if_id_valid;

   logic [31:0] w_imem_addr, w_imem_dout = 32'h0000_0000;
   logic        w_imem_en;
   logic [31:0] w_if_id_instr, w_if_id_pc;
   logic        w_if_id_valid;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cardinal_fetch_stage u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(imem_addr), .imem_en(imem_en), .imem_dout(imem_dout),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
   );

   cardinal_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(w_imem_addr), .imem_en(w_imem_en), .imem_dout(w_imem_dout),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .if_id_instr(w_if_id_instr), .if_id_pc(w_if_id_pc), .if_id_valid(w_if_id_valid)
   );

   // Synchronous instruction memories: data = address, one cycle after the enabled read.
   always @(posedge clk) begin
      if (imem_en) imem_dout <= imem_addr;
      if (w_imem_en) w_imem_dout <= w_imem_addr;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_word(input string tag, input logic [31:0] pc);
      check({tag, " valid"}, {31'd0, if_id_valid}, 32'd1);
      check({tag, " pc"}, if_id_pc, pc);
      check({tag, " instr"}, if_id_instr, pc);
   endtask

   task automatic expect_bubble(input string tag);
      check({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
      check({tag, " instr"}, if_id_instr, NOP);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("rst valid", {31'd0, if_id_valid}, 32'd0);
      check("rst instr", if_id_instr, NOP);
      check("rst pc", if_id_pc, 32'h0);
      check("rst imem_en", {31'd0, imem_en}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: start-up latency and sequential flow; wrap instance alongside
      tick();
      expect_bubble("t1 c1");
      tick();
      expect_word("t1 c2", 32'h0);
      check("wrap c2 pc", w_if_id_pc, 32'hFFFF_FFF8);
      check("wrap c2 valid", {31'd0, w_if_id_valid}, 32'd1);
      tick();
      expect_word("t1 c3", 32'h4);
      check("wrap c3 pc", w_if_id_pc, 32'hFFFF_FFFC);
      tick();
      expect_word("t1 c4", 32'h8);
      check("wrap c4 pc", w_if_id_pc, 32'h0000_0000);
      check("wrap c4 instr", w_if_id_instr, 32'h0000_0000);

      // 2: three-cycle stall holding pc 8
      stall = 1'b1;
      #1 check("t2 imem_en", {31'd0, imem_en}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_word("t2 hold", 32'h8);
         check("t2 imem_en hold", {31'd0, imem_en}, 32'd0);
      end
      stall = 1'b0;
      tick();
      expect_word("t2 r12", 32'hC);
      tick();
      expect_word("t2 r16", 32'h10);
      tick();
      expect_word("t2 r20", 32'h14);

      // 3: branch to unaligned target 0x103
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0103;
      #1;
      check("t3 imem_addr", imem_addr, 32'h0000_0100);
      check("t3 imem_en", {31'd0, imem_en}, 32'd1);
      tick();
      branch_taken = 1'b0;
      expect_bubble("t3 bubble");
      tick();
      expect_word("t3 tgt", 32'h100);
      tick();
      expect_word("t3 tgt+4", 32'h104);

      // 4: skid loaded (pc 0x108), then branch and stall together
      stall = 1'b1;
      tick();
      expect_word("t4 hold", 32'h104);
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0200;
      #1;
      check("t4 imem_addr", imem_addr, 32'h0000_0200);
      check("t4 imem_en", {31'd0, imem_en}, 32'd1);
      tick();
      branch_taken = 1'b0;
      stall        = 1'b0;
      expect_bubble("t4 bubble");
      tick();
      expect_word("t4 tgt", 32'h200);
      tick();
      expect_word("t4 tgt+4", 32'h204);

      // 5: asynchronous reset mid-cycle
      #2 rst_n = 1'b0;
      #1;
      expect_bubble("t5 async");
      check("t5 pc", if_id_pc, 32'h0);
      check("t5 imem_en", {31'd0, imem_en}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      expect_bubble("t5 c1");
      tick();
      expect_word("t5 c2", 32'h0);
      tick();
      expect_word("t5 c3", 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
